// File: rtl/pipeline.sv
// Two-stage carry-split pipelined adder.
// Stage 1 adds the low LO_W bits of each operand and registers the low sum,
// its carry-out, and the untouched high slices. Stage 2 adds the high slices
// plus that carry and registers the full WIDTH+1-bit result.
// A new operand pair is accepted on every rising edge. Results leave two edges
// after their operands are sampled.
// flush is a synchronous, active-high clear of every pipeline register.
// LO_W must lie in 1..WIDTH-1 so that both slices are non-empty.
module pipeline #(
    parameter int WIDTH = 8,
    parameter int LO_W  = 4
) (
    input  logic             clk,
    input  logic             flush,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH:0]   result
);

    localparam int HI_W = WIDTH - LO_W;

    // Stage-1 registers: the low-slice partial sum and the high operand slices
    // belonging to the same pair. Keeping them together stops a carry from
    // leaking into a neighbouring pair.
    logic [LO_W-1:0] s1_lo_sum;
    logic            s1_lo_carry;
    logic [HI_W-1:0] s1_a_hi;
    logic [HI_W-1:0] s1_b_hi;

    // Combinational adders. One spare bit on each sum catches the carry-out.
    logic [LO_W:0]   lo_full;
    logic [HI_W:0]   hi_full;

    // Low-slice addition of the incoming operands.
    always_comb begin
        lo_full = {1'b0, a[LO_W-1:0]} + {1'b0, b[LO_W-1:0]};
    end

    // Stage 1: capture the low sum, its carry, and the high slices.
    // flush takes priority, so the pair present at a flushing edge is dropped.
    always_ff @(posedge clk) begin
        // NOTE: registered state uses non-blocking assignments so that every
        // register samples values from before the edge, whatever the block order.
        if (flush) begin
            s1_lo_sum   <= '0;
            s1_lo_carry <= 1'b0;
            s1_a_hi     <= '0;
            s1_b_hi     <= '0;
        end else begin
            s1_lo_sum   <= lo_full[LO_W-1:0];
            s1_lo_carry <= lo_full[LO_W];
            s1_a_hi     <= a[WIDTH-1:LO_W];
            s1_b_hi     <= b[WIDTH-1:LO_W];
        end
    end

    // High-slice addition. It uses only stage-1 registers, so nothing on a or b
    // can reach result combinationally.
    always_comb begin
        hi_full = {1'b0, s1_a_hi} + {1'b0, s1_b_hi} + {{HI_W{1'b0}}, s1_lo_carry};
    end

    // Stage 2: join the high sum (including the final carry) with the low sum.
    always_ff @(posedge clk) begin
        if (flush) begin
            result <= '0;
        end else begin
            result <= {hi_full, s1_lo_sum};
        end
    end

endmodule

// File: tb/tb_pipeline.sv
// Self-checking bench for the two-stage pipelined adder (WIDTH=8, LO_W=4).
// A behavioural model works out the full sum a+b directly.
// A negedge compare process checks result against the model on every cycle
// once the first flush has made the pipeline state defined.
// Directed vectors with literal expectations pin the model itself.
module tb_pipeline;

    logic       clk;
    logic       flush;
    logic [7:0] a;
    logic [7:0] b;
    logic [8:0] result;

    int checks   = 0;
    int failures = 0;

    pipeline #(.WIDTH(8), .LO_W(4)) dut (
        .clk    (clk),
        .flush  (flush),
        .a      (a),
        .b      (b),
        .result (result)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural model: a two-deep delay line of exact 9-bit sums.
    // A flush empties the line to zero.
    logic [8:0] m_s1;
    logic [8:0] m_res;
    logic       m_valid = 1'b0;

    always @(posedge clk) begin
        if (flush) begin
            m_s1    <= 9'd0;
            m_res   <= 9'd0;
            m_valid <= 1'b1;
        end else begin
            m_s1    <= {1'b0, a} + {1'b0, b};
            m_res   <= m_s1;
        end
    end

    task automatic check(input string name, input logic [8:0] got, input logic [8:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%03h expected 0x%03h at %0t", name, got, exp, $time);
        end
    endtask

    // Compare the DUT against the model away from the active edge.
    always @(negedge clk) begin
        if (m_valid) check("model", result, m_res);
    end

    // Drive one edge's worth of inputs, let the edge happen, then settle.
    task automatic tick(input logic f, input logic [7:0] av, input logic [7:0] bv);
        flush = f;
        a     = av;
        b     = bv;
        @(posedge clk);
        #1;
    endtask

    initial begin
        flush = 1'b0;
        a     = 8'h00;
        b     = 8'h00;
        #2;

        // Reset: flush held for two edges.
        tick(1'b1, 8'h00, 8'h00);
        check("reset_edge1", result, 9'h000);
        tick(1'b1, 8'h00, 8'h00);
        check("reset_edge2", result, 9'h000);

        // Basic add with two-edge latency.
        tick(1'b0, 8'h03, 8'h02);
        check("after_flush_drop", result, 9'h000);
        tick(1'b0, 8'h0F, 8'h01);
        check("add_3_2", result, 9'h005);

        // Carry across the slice boundary.
        tick(1'b0, 8'h88, 8'h88);
        check("add_0f_01", result, 9'h010);
        tick(1'b0, 8'hFF, 8'hFF);
        check("add_88_88", result, 9'h110);

        // Maximum and zero operands.
        tick(1'b0, 8'h00, 8'h00);
        check("add_ff_ff", result, 9'h1FE);
        tick(1'b0, 8'h01, 8'h01);
        check("add_00_00", result, 9'h000);

        // Back-to-back streaming.
        tick(1'b0, 8'h02, 8'h02);
        check("stream_1_1", result, 9'h002);
        tick(1'b0, 8'hF0, 8'h10);
        check("stream_2_2", result, 9'h004);
        tick(1'b0, 8'h00, 8'h00);
        check("stream_f0_10", result, 9'h100);

        // Flush mid-flight: 3+2 is sampled, then flushed before it can emerge.
        tick(1'b0, 8'h03, 8'h02);
        tick(1'b1, 8'h09, 8'h09);
        check("flush_kills_inflight", result, 9'h000);
        tick(1'b0, 8'h07, 8'h07);
        check("flush_discards_pair", result, 9'h000);
        tick(1'b0, 8'h00, 8'h00);
        check("resume_7_7", result, 9'h00E);

        // Pseudo-random stream with occasional flushes, checked by the model.
        for (int i = 0; i < 60; i++) begin
            tick(($urandom_range(0, 9) == 0), 8'($urandom), 8'($urandom));
        end
        tick(1'b0, 8'h00, 8'h00);
        tick(1'b0, 8'h00, 8'h00);

        @(negedge clk);
        #1;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/pipeline.md
PIPELINE -- requirements
Module: pipeline

Interface
REQ-001 Parameter WIDTH, default 8: operand width in bits; the result is WIDTH+1 bits.
REQ-002 Parameter LO_W, default 4: width of the low operand slice added in stage 1; legal range 1 to WIDTH-1.
REQ-003 Port clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-004 Port flush, input, 1 bit: reset, synchronous and active-high; clears all pipeline state.
REQ-005 Port a, input, WIDTH bits: unsigned operand A, sampled every rising edge.
REQ-006 Port b, input, WIDTH bits: unsigned operand B, sampled every rising edge.
REQ-007 Port result, output, WIDTH+1 bits: registered unsigned sum a+b, including the carry-out in the MSB.

Function
REQ-008 The block SHALL be a two-stage, carry-split pipelined adder that accepts one new operand pair on every rising edge, with no stalls and no handshake.
REQ-009 Stage 1 SHALL, at each rising edge with flush low, register the following values:
- low sum: a[LO_W-1:0] + b[LO_W-1:0], truncated to LO_W bits
- low carry: the carry-out of that low addition
- a_hi = a[WIDTH-1:LO_W] and b_hi = b[WIDTH-1:LO_W]
REQ-010 Stage 2 SHALL, at each rising edge with flush low, set result = {a_hi + b_hi + low carry, low sum}; the high part is (WIDTH-LO_W+1) bits.
REQ-011 Latency: an operand pair sampled at rising edge N SHALL appear on result after rising edge N+1 and remain stable until edge N+2.
REQ-012 Throughput SHALL be one result per clock; consecutive operand pairs SHALL produce consecutive results in the same order.
REQ-013 Arithmetic SHALL be unsigned and exact: no overflow, saturation or wrap in the WIDTH+1-bit result (0xFF+0xFF = 0x1FE for WIDTH=8).
REQ-014 A carry out of the low slice SHALL propagate into the high slice of the same operand pair, never into a neighbouring pair.
REQ-015 result SHALL come directly from a register; there is no combinational path from a or b to result.
REQ-016 Input changes between rising edges SHALL have no effect on state.

Reset
REQ-017 When flush is high at a rising edge, all stage-1 registers and result SHALL become 0 on that edge.
REQ-018 flush SHALL take priority over new operands: the pair present at a flushing edge SHALL be discarded.
REQ-019 Operands in flight when flush asserts mid-operation SHALL never reach result.
REQ-020 The first valid sample after flush SHALL be taken at the first rising edge with flush low; its result SHALL appear one edge later.
REQ-021 While flush stays high, result SHALL remain 0.
REQ-022 Power-up state before the first flush is undefined; the bench SHALL apply flush before checking result.

Verification
REQ-023 Reset: hold flush=1 for 2 edges with a=b=0 -> result=0x000 throughout and after.
REQ-024 Basic add: flush=0, a=0x03, b=0x02 sampled at edge N -> result=0x005 after edge N+1.
REQ-025 Carry across the slice boundary: a=0x0F, b=0x01 -> result=0x010; a=0x88, b=0x88 -> result=0x110.
REQ-026 Maximum: a=0xFF, b=0xFF -> result=0x1FE; a=0x00, b=0x00 -> result=0x000.
REQ-027 Back-to-back streaming: apply pairs (1,1), (2,2), (0xF0,0x10) on consecutive edges -> result is 0x002, 0x004, 0x100 on consecutive edges.
REQ-028 Flush mid-flight: a=0x03, b=0x02 sampled at edge N, flush=1 at edge N+1 -> result=0x000 after edge N+1 and 5 never appears; after flush drops, normal operation resumes with two-edge latency.
